// File: rtl/rca_ctrl_pkg.sv
// Shared definitions for the byte-serial adder sequencer.
//   state_t   : FSM encoding (IDLE, RUN, DONE) in 2 bits
//   BYTE_W    : width of one adder slice
//   idx_width : width of the byte index register, never less than 1 bit
package rca_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nbytes);
    int w;
    w = $clog2(nbytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/RCA_8bits.sv
// 8-bit ripple-carry adder slice.
// Ports:
//   cout : carry out of bit 7
//   sum  : 8-bit sum
//   x, y : addends
//   cin  : carry into bit 0
module RCA_8bits (
  output logic       cout,
  output logic [7:0] sum,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = c[8];

endmodule

// File: rtl/rca_serial_ctrl.sv
// Byte-serial wide adder: one shared 8-bit ripple-carry slice is stepped
// over the operands LSB byte first, with the carry held in a register
// between bytes. Latency is NBYTES cycles from acceptance to out_valid.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready: result handshake (sum, cout held until taken)
//   busy                 : high whenever not idle
module rca_serial_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     busy
);

  localparam int                OPW       = BYTE_W * NBYTES;
  localparam int                IDXW      = idx_width(NBYTES);
  localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(NBYTES - 1);
  localparam logic [OPW-1:0]    BYTE_MASK = OPW'({BYTE_W{1'b1}});

  state_t             state;
  logic [OPW-1:0]     a_q;
  logic [OPW-1:0]     b_q;
  logic [OPW-1:0]     res_q;
  logic [IDXW-1:0]    idx;
  logic               carry;
  logic               cout_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [IDXW+2:0]    shamt;
  logic [BYTE_W-1:0]  x_byte;
  logic [BYTE_W-1:0]  y_byte;
  logic [BYTE_W-1:0]  s_byte;
  logic               add_cout;
  logic [OPW-1:0]     byte_sel;
  logic [OPW-1:0]     res_next;

  // Byte select: bit offset of the current byte is idx*8. Shifting rather
  // than indexing keeps the NBYTES=1 case (1-bit idx, single byte) legal.
  assign shamt    = {idx, 3'b000};
  assign x_byte   = BYTE_W'(a_q >> shamt);
  assign y_byte   = BYTE_W'(b_q >> shamt);
  assign byte_sel = BYTE_MASK << shamt;
  assign res_next = (res_q & ~byte_sel) | (OPW'(s_byte) << shamt);

  RCA_8bits u_add (
    .cout (add_cout),
    .sum  (s_byte),
    .x    (x_byte),
    .y    (y_byte),
    .cin  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            carry  <= cin;
            res_q  <= '0;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q <= res_next;
          carry <= add_cout;
          idx   <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            cout_q      <= add_cout;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = res_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rca_serial_ctrl.sv
// Testbench for rca_serial_ctrl: a 4-byte and a 1-byte instance share one
// clock and reset. Accepted requests push (a+b+cin) into a per-instance
// queue; monitors pop and compare whenever a result is handed over, and
// also check latency, output hold under backpressure and in_ready in DONE.
module tb_rca_serial_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv4, ir4, ov4, or4, cin4, co4, busy4;
  logic [31:0] a4, b4, s4;
  logic        iv1, ir1, ov1, or1, cin1, co1, busy1;
  logic [7:0]  a1, b1, s1;

  rca_serial_ctrl #(.NBYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(busy4)
  );

  rca_serial_ctrl #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(busy1)
  );

  typedef struct {
    logic [32:0] r;
    int          t;
  } exp_t;

  exp_t        q4[$];
  exp_t        q1[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edges = 0;
  bit          bp4 = 1'b0;
  bit          pv4 = 1'b0;
  bit          pv1 = 1'b0;
  logic [31:0] hs4;
  logic        hc4;
  logic [7:0]  hs1;
  logic        hc1;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference model: exact (width+1)-bit addition of the accepted operands.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (iv4 && ir4) q4.push_back('{r: {1'b0, a4} + {1'b0, b4} + 33'(cin4), t: edges});
      if (iv1 && ir1) q1.push_back('{r: 33'({1'b0, a1} + {1'b0, b1} + 9'(cin1)), t: edges});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) pv4 = 1'b0;
    else begin
      if (ov4 && !pv4) begin
        if (q4.size() == 0) flag("d4_spurious_out_valid");
        else chk("d4_latency", 64'(edges - q4[0].t - 1), 64'd4);
      end else if (ov4) begin
        chk("d4_hold_sum", 64'(s4), 64'(hs4));
        chk("d4_hold_cout", 64'(co4), 64'(hc4));
      end
      if (ov4) chk("d4_in_ready_in_done", 64'(ir4), 64'd0);
      hs4 = s4;
      hc4 = co4;
      if (ov4 && or4) begin
        if (q4.size() == 0) flag("d4_result_without_request");
        else begin
          e = q4.pop_front();
          chk("d4_sum", 64'(s4), 64'(e.r[31:0]));
          chk("d4_cout", 64'(co4), 64'(e.r[32]));
        end
      end
      pv4 = ov4 && !or4;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'b1) pv1 = 1'b0;
    else begin
      if (ov1 && !pv1) begin
        if (q1.size() == 0) flag("d1_spurious_out_valid");
        else chk("d1_latency", 64'(edges - q1[0].t - 1), 64'd1);
      end else if (ov1) begin
        chk("d1_hold_sum", 64'(s1), 64'(hs1));
        chk("d1_hold_cout", 64'(co1), 64'(hc1));
      end
      if (ov1) chk("d1_in_ready_in_done", 64'(ir1), 64'd0);
      hs1 = s1;
      hc1 = co1;
      if (ov1 && or1) begin
        if (q1.size() == 0) flag("d1_result_without_request");
        else begin
          e = q1.pop_front();
          chk("d1_sum", 64'(s1), 64'(e.r[7:0]));
          chk("d1_cout", 64'(co1), 64'(e.r[8]));
        end
      end
      pv1 = ov1 && !or1;
    end
  end

  // Random backpressure on the 4-byte instance when enabled.
  always @(posedge clk) begin
    #1;
    if (bp4) or4 = 1'($urandom_range(0, 1));
  end

  task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic c);
    bit rdy;
    int n = 0;
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
    do begin
      rdy = ir4;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) flag("d4_accept_timeout");
    iv4 = 1'b0;
    a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom_range(0, 1));
  endtask

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic c);
    bit rdy;
    int n = 0;
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    do begin
      rdy = ir1;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) flag("d1_accept_timeout");
    iv1 = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((q4.size() != 0 || q1.size() != 0 || ir4 !== 1'b1 || ir1 !== 1'b1) && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= lim) flag("drain_timeout");
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready4"}, 64'(ir4), 64'd1);
    chk({tag, "_out_valid4"}, 64'(ov4), 64'd0);
    chk({tag, "_busy4"}, 64'(busy4), 64'd0);
    chk({tag, "_sum4"}, 64'(s4), 64'd0);
    chk({tag, "_cout4"}, 64'(co4), 64'd0);
    chk({tag, "_in_ready1"}, 64'(ir1), 64'd1);
    chk({tag, "_out_valid1"}, 64'(ov1), 64'd0);
    chk({tag, "_busy1"}, 64'(busy1), 64'd0);
    chk({tag, "_sum1"}, 64'(s1), 64'd0);
    chk({tag, "_cout1"}, 64'(co1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int t0;
    int t1;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on the 4-byte instance.
    issue4(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
    chk("d4_busy_in_run", 64'(busy4), 64'd1);
    issue4(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue4(32'hFFFFFFFF, 32'h00000000, 1'b1);
    issue4(32'h00000000, 32'h00000000, 1'b1);
    issue4(32'h000000FF, 32'h00000001, 1'b0);
    drain(200);

    // Backpressure in DONE with an ignored request on the input side.
    or4 = 1'b0;
    issue4(32'h9ABCDEF0, 32'h87654321, 1'b1);
    n = 0;
    while (!ov4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ov4) flag("bp_out_valid_timeout");
    iv4 = 1'b1; a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 1'b0;
    repeat (5) begin
      chk("bp_out_valid", 64'(ov4), 64'd1);
      chk("bp_in_ready", 64'(ir4), 64'd0);
      chk("bp_sum", 64'(s4), 64'h22222212);
      chk("bp_cout", 64'(co4), 64'd1);
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_handshake", 64'(ir4), 64'd1);
    chk("out_valid_after_handshake", 64'(ov4), 64'd0);
    drain(200);

    // Reset after two of four bytes have been processed.
    issue4(32'h01010101, 32'h01010101, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    reset_checks("midrun_reset");
    q4.delete();
    q1.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue4(32'h01010101, 32'h01010101, 1'b0);
    drain(200);

    // Randomized operands with random backpressure.
    bp4 = 1'b1;
    repeat (25) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h00000000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
      issue4(ra, rb, 1'($urandom_range(0, 1)));
    end
    bp4 = 1'b0;
    @(posedge clk); #1;
    or4 = 1'b1;
    drain(1000);

    // Single-byte configuration.
    issue1(8'hFF, 8'hFF, 1'b0);
    drain(50);
    issue1(8'h80, 8'h80, 1'b1);
    t0 = edges;
    issue1(8'h0F, 8'hF0, 1'b1);
    t1 = edges;
    chk("d1_issue_interval_a", 64'(t1 - t0), 64'd3);
    issue1(8'($urandom), 8'($urandom), 1'b0);
    t0 = edges;
    chk("d1_issue_interval_b", 64'(t0 - t1), 64'd3);
    repeat (20) issue1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
